id_ex_stage: RTL

- ID/EX pipeline register and operand-forwarding stage. It sits directly upstream of the ALU and drives its srca_i, srcb_i and aluop_i.
- Captures decoded ID-stage fields on each clock. Resolves RAW hazards by forwarding from EX/MEM and MEM/WB. Selects the immediate or shift amount for operand B.
- Detects load-use hazards and inserts one bubble for each one.

---
 rtl/id_ex_stage_pkg.sv | 20 ++
 rtl/id_ex_stage_fwd_mux.sv | 40 ++++
 rtl/id_ex_stage.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared encodings for the ID/EX stage: ALU op reused by bubbles, operand-B
// source codes and forwarding select codes.
package id_ex_stage_pkg;

    localparam logic [3:0] ALU_ADD = 4'd2;

    typedef enum logic [1:0] {
        ALUSRC_RT    = 2'b00,
        ALUSRC_SIMM  = 2'b01,
        ALUSRC_ZIMM  = 2'b10,
        ALUSRC_SHAMT = 2'b11
    } alusrc_e;

    typedef enum logic [1:0] {
        FWD_REG   = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Combinational operand forwarding for one source register: EX/MEM first,
// then MEM/WB, else the value read from the register file.
module id_ex_stage_fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic [RW-1:0] idx_i,
    input  logic [DW-1:0] reg_data_i,
    input  logic          exmem_regwrite_i,
    input  logic [RW-1:0] exmem_wreg_i,
    input  logic [DW-1:0] exmem_result_i,
    input  logic          memwb_regwrite_i,
    input  logic [RW-1:0] memwb_wreg_i,
    input  logic [DW-1:0] memwb_result_i,
    output logic [DW-1:0] data_o,
    output fwd_sel_e      sel_o
);

    // r0 is hard-wired to zero, so a producer targeting it is never a source
    always_comb begin
        sel_o = FWD_REG;
        if (exmem_regwrite_i && (exmem_wreg_i != '0) && (exmem_wreg_i == idx_i)) begin
            sel_o = FWD_EXMEM;
        end else if (memwb_regwrite_i && (memwb_wreg_i != '0) && (memwb_wreg_i == idx_i)) begin
            sel_o = FWD_MEMWB;
        end
    end

    always_comb begin
        data_o = reg_data_i;
        case (sel_o)
            FWD_EXMEM: data_o = exmem_result_i;
            FWD_MEMWB: data_o = memwb_result_i;
            default:   data_o = reg_data_i;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with RAW forwarding, operand selection for the ALU
// and single-bubble load-use hazard insertion.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall_i,
    input  logic          flush_i,
    input  logic          id_valid_i,
    input  logic [RW-1:0] id_rs_i,
    input  logic [RW-1:0] id_rt_i,
    input  logic [DW-1:0] id_rs_data_i,
    input  logic [DW-1:0] id_rt_data_i,
    input  logic [15:0]   id_imm_i,
    input  logic [4:0]    id_shamt_i,
    input  logic [3:0]    id_aluop_i,
    input  logic          id_srca_rt_i,
    input  logic [1:0]    id_alusrc_i,
    input  logic [RW-1:0] id_wreg_i,
    input  logic          id_regwrite_i,
    input  logic          id_memread_i,
    input  logic          id_memwrite_i,
    input  logic          exmem_regwrite_i,
    input  logic [RW-1:0] exmem_wreg_i,
    input  logic [DW-1:0] exmem_result_i,
    input  logic          memwb_regwrite_i,
    input  logic [RW-1:0] memwb_wreg_i,
    input  logic [DW-1:0] memwb_result_i,
    output logic [DW-1:0] srca_o,
    output logic [DW-1:0] srcb_o,
    output logic [3:0]    aluop_o,
    output logic [DW-1:0] ex_rt_data_o,
    output logic          ex_valid_o,
    output logic          ex_regwrite_o,
    output logic          ex_memread_o,
    output logic          ex_memwrite_o,
    output logic [RW-1:0] ex_wreg_o,
    output logic          load_use_o
);

    typedef struct packed {
        logic          valid;
        logic          regwrite;
        logic          memread;
        logic          memwrite;
        logic [3:0]    aluop;
        logic          srca_rt;
        alusrc_e       alusrc;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] wreg;
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
        logic [15:0]   imm;
        logic [4:0]    shamt;
    } ex_t;

    ex_t           ex_d, ex_q, bubble, capture;
    logic [DW-1:0] rs_fwd, rt_fwd;
    fwd_sel_e      rs_sel_unused, rt_sel_unused;

    // Hazard is not masked by flush; upstream discards it in that case
    always_comb begin
        load_use_o = ex_q.memread && (ex_q.wreg != '0) && id_valid_i &&
                     ((id_rs_i == ex_q.wreg) || (id_rt_i == ex_q.wreg));
    end

    always_comb begin
        bubble       = '0;
        bubble.aluop = ALU_ADD;

        capture.valid    = id_valid_i;
        capture.regwrite = id_valid_i & id_regwrite_i;
        capture.memread  = id_valid_i & id_memread_i;
        capture.memwrite = id_valid_i & id_memwrite_i;
        capture.aluop    = id_aluop_i;
        capture.srca_rt  = id_srca_rt_i;
        capture.alusrc   = alusrc_e'(id_alusrc_i);
        capture.rs       = id_rs_i;
        capture.rt       = id_rt_i;
        capture.wreg     = id_wreg_i;
        capture.rs_data  = id_rs_data_i;
        capture.rt_data  = id_rt_data_i;
        capture.imm      = id_imm_i;
        capture.shamt    = id_shamt_i;

        // Stall outranks load-use so a held load keeps its hazard alive
        ex_d = ex_q;
        if (flush_i) begin
            ex_d = bubble;
        end else if (stall_i) begin
            ex_d = ex_q;
        end else if (load_use_o) begin
            ex_d = bubble;
        end else begin
            ex_d = capture;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q       <= '0;
            ex_q.aluop <= ALU_ADD;
        end else begin
            ex_q <= ex_d;
        end
    end

    id_ex_stage_fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
        .idx_i            (ex_q.rs),
        .reg_data_i       (ex_q.rs_data),
        .exmem_regwrite_i (exmem_regwrite_i),
        .exmem_wreg_i     (exmem_wreg_i),
        .exmem_result_i   (exmem_result_i),
        .memwb_regwrite_i (memwb_regwrite_i),
        .memwb_wreg_i     (memwb_wreg_i),
        .memwb_result_i   (memwb_result_i),
        .data_o           (rs_fwd),
        .sel_o            (rs_sel_unused)
    );

    id_ex_stage_fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
        .idx_i            (ex_q.rt),
        .reg_data_i       (ex_q.rt_data),
        .exmem_regwrite_i (exmem_regwrite_i),
        .exmem_wreg_i     (exmem_wreg_i),
        .exmem_result_i   (exmem_result_i),
        .memwb_regwrite_i (memwb_regwrite_i),
        .memwb_wreg_i     (memwb_wreg_i),
        .memwb_result_i   (memwb_result_i),
        .data_o           (rt_fwd),
        .sel_o            (rt_sel_unused)
    );

    always_comb begin
        srca_o = ex_q.srca_rt ? rt_fwd : rs_fwd;
        case (ex_q.alusrc)
            ALUSRC_SIMM:  srcb_o = {{(DW-16){ex_q.imm[15]}}, ex_q.imm};
            ALUSRC_ZIMM:  srcb_o = {{(DW-16){1'b0}}, ex_q.imm};
            ALUSRC_SHAMT: srcb_o = {{(DW-5){1'b0}}, ex_q.shamt};
            default:      srcb_o = rt_fwd;
        endcase
    end

    assign aluop_o       = ex_q.aluop;
    assign ex_rt_data_o  = rt_fwd;
    assign ex_valid_o    = ex_q.valid;
    assign ex_regwrite_o = ex_q.regwrite;
    assign ex_memread_o  = ex_q.memread;
    assign ex_memwrite_o = ex_q.memwrite;
    assign ex_wreg_o     = ex_q.wreg;

endmodule
